// File: rtl/cdiv_pkg.sv
// Shared types and default sizing for the iterative complex divider.
package cdiv_pkg;

    localparam int CDIV_WIDTH  = 16;
    localparam int CDIV_FRAC   = 12;
    localparam int CDIV_PROD_W = 2*CDIV_WIDTH + 1;
    localparam int CDIV_DVD_W  = CDIV_PROD_W + CDIV_FRAC;

    localparam logic [CDIV_WIDTH-1:0] CDIV_SAT_POS = {1'b0, {(CDIV_WIDTH-1){1'b1}}};
    localparam logic [CDIV_WIDTH-1:0] CDIV_SAT_NEG = {1'b1, {(CDIV_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROD,
        ST_DIV_RE,
        ST_DIV_IM,
        ST_DONE
    } cdiv_state_e;

endpackage

// File: rtl/cdiv_udiv.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// The start cycle performs the first step, so WIDTH edges yield the full quotient.
module cdiv_udiv #(
    parameter int WIDTH = 16,
    parameter int DVD_W = 45,
    parameter int DVS_W = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o
);

    localparam int RW = DVS_W;
    localparam int CW = $clog2(WIDTH + 1);

    logic [RW-1:0]    rem_q, rem_d, rem_src;
    logic [WIDTH-1:0] lo_q, lo_d, lo_src;
    logic [WIDTH-1:0] q_q, q_d, q_src;
    logic [CW-1:0]    cnt_q;
    logic [RW:0]      trial, diff;
    logic             ge, step;

    assign busy_o = (cnt_q != '0);
    assign step   = start_i || busy_o;

    always_comb begin
        rem_src = start_i ? RW'(dividend_i[DVD_W-1:WIDTH]) : rem_q;
        lo_src  = start_i ? dividend_i[WIDTH-1:0] : lo_q;
        q_src   = start_i ? '0 : q_q;
        trial   = {rem_src, lo_src[WIDTH-1]};
        diff    = trial - {1'b0, divisor_i};
        ge      = (trial >= {1'b0, divisor_i});
        rem_d   = ge ? diff[RW-1:0] : trial[RW-1:0];
        lo_d    = lo_src << 1;
        q_d     = {q_src[WIDTH-2:0], ge};
    end

    // The quotient is exposed combinationally so the caller can capture it on the final step.
    assign quot_o = q_d;
    assign done_o = start_i ? (WIDTH == 1) : (cnt_q == CW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q <= '0;
            lo_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= rem_d;
            lo_q  <= lo_d;
            q_q   <= q_d;
            cnt_q <= start_i ? CW'(WIDTH - 1) : cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/cdiv.sv
// Iterative fixed-point complex divider: quotient = num / den for packed {re, im}.
// Fixed latency: products in one cycle, then WIDTH divide steps per component.
import cdiv_pkg::*;

module cdiv #(
    parameter int WIDTH = CDIV_WIDTH,
    parameter int FRAC  = CDIV_FRAC
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2*WIDTH-1:0] i_num,
    input  logic [2*WIDTH-1:0] i_den,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_quot,
    output logic               o_div0
);

    localparam int PW   = 2*WIDTH + 1;
    localparam int DW   = PW + FRAC;
    localparam int CMPW = PW + WIDTH;
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    cdiv_state_e state_q, state_d;

    logic signed [WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic signed [PW-1:0]    ax, bx, cx, dx, nr_c, ni_c, den_c;
    logic [PW-1:0]           nr_mag_q, ni_mag_q, den_q;
    logic                    nr_neg_q, ni_neg_q, div0_q;
    logic [WIDTH-1:0]        re_q, im_q;

    logic             act_im, act_neg, ovf, start, busy, done;
    logic [PW-1:0]    act_mag;
    logic [CMPW-1:0]  ovf_lhs, ovf_rhs;
    logic [WIDTH-1:0] uq, fmt;

    function automatic logic [WIDTH-1:0] sat_fmt(input logic [WIDTH-1:0] mag,
                                                 input logic neg, input logic sat,
                                                 input logic zden);
        logic [WIDTH-1:0] r;
        if (zden || (mag == '0 && !sat))
            r = '0;
        else if (!neg)
            r = (sat || mag > SAT_POS) ? SAT_POS : mag;
        else
            r = (sat || mag > SAT_NEG) ? SAT_NEG : -mag;
        return r;
    endfunction

    assign ax    = PW'(a_q);
    assign bx    = PW'(b_q);
    assign cx    = PW'(c_q);
    assign dx    = PW'(d_q);
    assign nr_c  = ax*cx + bx*dx;
    assign ni_c  = bx*cx - ax*dx;
    assign den_c = cx*cx + dx*dx;

    assign act_im  = (state_q == ST_DIV_IM);
    assign act_mag = act_im ? ni_mag_q : nr_mag_q;
    assign act_neg = act_im ? ni_neg_q : nr_neg_q;
    // Product registers are frozen during a phase, so this equals the value at phase entry.
    assign ovf_lhs = CMPW'(act_mag) << FRAC;
    assign ovf_rhs = CMPW'(den_q) << WIDTH;
    assign ovf     = (ovf_lhs >= ovf_rhs);
    assign fmt     = sat_fmt(uq, act_neg, ovf, div0_q);

    cdiv_udiv #(
        .WIDTH (WIDTH),
        .DVD_W (DW),
        .DVS_W (PW)
    ) u_udiv (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .start_i    (start),
        .dividend_i ({act_mag, {FRAC{1'b0}}}),
        .divisor_i  (den_q),
        .busy_o     (busy),
        .done_o     (done),
        .quot_o     (uq)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (i_valid) state_d = ST_PROD;
            ST_PROD:   state_d = ST_DIV_RE;
            ST_DIV_RE: begin
                start = !busy;
                if (done) state_d = ST_DIV_IM;
            end
            ST_DIV_IM: begin
                start = !busy;
                if (done) state_d = ST_DONE;
            end
            ST_DONE:   if (i_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            nr_mag_q <= '0;
            ni_mag_q <= '0;
            den_q    <= '0;
            nr_neg_q <= 1'b0;
            ni_neg_q <= 1'b0;
            div0_q   <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && i_valid) begin
                a_q <= i_num[2*WIDTH-1:WIDTH];
                b_q <= i_num[WIDTH-1:0];
                c_q <= i_den[2*WIDTH-1:WIDTH];
                d_q <= i_den[WIDTH-1:0];
            end
            if (state_q == ST_PROD) begin
                nr_neg_q <= nr_c[PW-1];
                ni_neg_q <= ni_c[PW-1];
                nr_mag_q <= nr_c[PW-1] ? -nr_c : nr_c;
                ni_mag_q <= ni_c[PW-1] ? -ni_c : ni_c;
                den_q    <= den_c;
                div0_q   <= (den_c == '0);
            end
            if (done && state_q == ST_DIV_RE) re_q <= fmt;
            if (done && state_q == ST_DIV_IM) im_q <= fmt;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_quot  = {re_q, im_q};
    assign o_div0  = div0_q;

endmodule

// File: tb/tb_cdiv.sv
// Self-checking bench for cdiv: directed table, corner sequences, randomized ops vs arithmetic model.
module tb_cdiv;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, o_valid, i_ready, o_div0;
    logic [31:0] i_num, i_den, o_quot;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 i_clk = ~i_clk;

    cdiv dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_num   (i_num),
        .i_den   (i_den),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_quot  (o_quot),
        .o_div0  (o_div0)
    );

    typedef struct {
        string       name;
        logic [31:0] num;
        logic [31:0] den;
        logic [31:0] quot;
        logic        div0;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Quotient component from plain integer arithmetic: truncate toward zero, then clamp.
    function automatic logic [15:0] ref_comp(input longint n, input longint d);
        longint mag, q;
        if (d == 0) return 16'h0000;
        mag = (n < 0) ? -n : n;
        q   = (mag * 4096) / d;
        if (q == 0) return 16'h0000;
        if (n >= 0) return (q > 32767) ? 16'h7FFF : 16'(q);
        return (q > 32768) ? 16'h8000 : 16'(-q);
    endfunction

    task automatic ref_div(input logic [31:0] num, input logic [31:0] den,
                           output logic [31:0] quot, output logic div0);
        shortint sa, sb, sc, sd;
        longint  a, b, c, d, nr, ni, dd;
        sa = num[31:16]; sb = num[15:0]; sc = den[31:16]; sd = den[15:0];
        a = sa; b = sb; c = sc; d = sd;
        nr = a*c + b*d;
        ni = b*c - a*d;
        dd = c*c + d*d;
        div0 = (dd == 0);
        quot = {ref_comp(nr, dd), ref_comp(ni, dd)};
    endtask

    function automatic logic [15:0] rnd_comp(input int sh);
        logic signed [15:0] v;
        v = 16'($urandom);
        return v >>> sh;
    endfunction

    task automatic run_op(input string nm, input logic [31:0] num, input logic [31:0] den,
                          input logic [31:0] exp_q, input logic exp_d,
                          input int hold, input logic early);
        int          lat;
        logic        stable;
        logic [31:0] q0;
        i_num   = num;
        i_den   = den;
        i_valid = 1'b1;
        i_ready = early;
        chk({nm, ".ready"}, 64'(o_ready), 64'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_num   = $urandom;
        i_den   = $urandom;
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
        end
        chk({nm, ".latency"}, 64'(lat), 64'd33);
        chk({nm, ".quot"}, 64'(o_quot), 64'(exp_q));
        chk({nm, ".div0"}, 64'(o_div0), 64'(exp_d));
        q0 = o_quot;
        if (!early && hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(posedge i_clk); #1;
                if (o_valid !== 1'b1 || o_quot !== q0) stable = 1'b0;
            end
            chk({nm, ".hold"}, 64'(stable), 64'd1);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk({nm, ".return"}, {62'd0, o_valid, o_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] eq, num, den;
        logic        ed, seen;

        tbl.push_back('{"one",      32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 1'b0});
        tbl.push_back('{"i_ratio",  32'h1000_1000, 32'h1000_F000, 32'h0000_1000, 1'b0});
        tbl.push_back('{"two_half", 32'h2000_0000, 32'h0000_0800, 32'h0000_C000, 1'b0});
        tbl.push_back('{"sat_pos",  32'h7000_0000, 32'h0400_0000, 32'h7FFF_0000, 1'b0});
        tbl.push_back('{"sat_neg",  32'h9000_0000, 32'h0400_0000, 32'h8000_0000, 1'b0});
        tbl.push_back('{"div0",     32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1});
        tbl.push_back('{"neg_8",    32'h8000_0000, 32'h1000_0000, 32'h8000_0000, 1'b0});
        tbl.push_back('{"pos_8",    32'h4000_0000, 32'h0800_0000, 32'h7FFF_0000, 1'b0});
        tbl.push_back('{"third",    32'h1000_0000, 32'h3000_0000, 32'h0555_0000, 1'b0});
        tbl.push_back('{"m_third",  32'hF000_0000, 32'h3000_0000, 32'hFAAB_0000, 1'b0});
        tbl.push_back('{"zero_num", 32'h0000_0000, 32'h1234_0567, 32'h0000_0000, 1'b0});

        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_num = '0; i_den = '0;
        #1;
        chk("reset.outputs", {o_ready, o_valid, o_div0, o_quot}, {3'b100, 32'h0});
        #20;
        @(negedge i_clk) i_rst = 1'b0;
        @(posedge i_clk); #1;

        foreach (tbl[k])
            run_op(tbl[k].name, tbl[k].num, tbl[k].den, tbl[k].quot, tbl[k].div0, k % 3, 1'b0);

        run_op("backpressure", 32'h1000_1000, 32'h1000_F000, 32'h0000_1000, 1'b0, 5, 1'b0);

        // Reset ten cycles into an operation: no result may follow.
        i_num = 32'h1000_0000; i_den = 32'h1000_0000; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 i_rst = 1'b1;
        #1 chk("midrst.ready", {62'd0, o_ready, o_valid}, 64'd2);
        @(posedge i_clk); #1 i_rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        chk("midrst.no_valid", 64'(seen), 64'd0);
        run_op("after_rst", 32'h2000_0000, 32'h0000_0800, 32'h0000_C000, 1'b0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            num = {rnd_comp($urandom_range(0, 6)), rnd_comp($urandom_range(0, 6))};
            den = (k % 10 == 9) ? 32'h0 :
                  {rnd_comp($urandom_range(0, 8)), rnd_comp($urandom_range(0, 8))};
            ref_div(num, den, eq, ed);
            run_op($sformatf("rand%0d", k), num, den, eq, ed,
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdiv.md
# cdiv

Iterative fixed-point complex divider. It computes `i_num / i_den` for packed {real, imag} operands. It is the inverse companion to the pipelined complex multiplier and sits beside it in the datapath wherever channel or gain equalisation needs a quotient. It uses a valid/ready handshake on both sides and has a fixed, data-independent latency. It is a single-issue unit: one operation is in flight at a time.

## Interface
- `WIDTH`, 16: bits per real or imag component, signed two's complement.
- `FRAC`, 12: fractional bits. The component format is Q(WIDTH-FRAC).FRAC.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  operands valid.
- `o_ready`  out  1  unit idle and able to accept operands.
- `i_num`  in  2*WIDTH  numerator, packed {real, imag}.
- `i_den`  in  2*WIDTH  denominator, packed {real, imag}.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_quot`  out  2*WIDTH  quotient, packed {real, imag}.
- `o_div0`  out  1  denominator was zero; qualified by `o_valid`.

## Operation
- States: IDLE, PROD, DIV_RE, DIV_IM, DONE.
- `o_ready` = (state == IDLE).
- IDLE: on `i_valid && o_ready`, latch the operands and go to PROD.
- PROD (1 cycle): with numerator a+bi and denominator c+di, register:
  - Nr = a*c + b*d
  - Ni = b*c - a*d
  - D = c*c + d*d
  - Each is 2*WIDTH+1 bits with 2*FRAC fractional bits.
  - Also register the sign and magnitude of Nr and Ni, and the flag div0 = (D == 0).
  - Then go to DIV_RE.
- DIV_RE, then DIV_IM: each runs exactly WIDTH cycles of restoring shift-subtract division, computing |N|·2^FRAC / D. The result is an unsigned WIDTH-bit magnitude, truncated toward zero.
- Overflow precheck at phase entry: if |N|·2^FRAC ≥ D·2^WIDTH, the component saturates. The phase still spends all WIDTH cycles.
- Sign and saturation for each component:
  - Positive result: a magnitude above 2^(WIDTH-1)-1 clamps to 0x7FFF.
  - Negative result: a magnitude above 2^(WIDTH-1) clamps to 0x8000; otherwise the output is the negated magnitude.
  - A zero magnitude is always 0 (no -0 case).
- div0: both components are forced to 0 and `o_div0` = 1. The latency is unchanged.
- DONE: `o_valid` = 1. `o_quot` and `o_div0` hold stable until `i_ready`. On `o_valid && i_ready`, go to IDLE.
- A new operand cannot be accepted in the same cycle as the output handshake, because `o_ready` is 0 in DONE.

## Timing
- Reset values:
  - state = IDLE
  - `o_valid` = 0
  - `o_quot` = 0
  - `o_div0` = 0
  - all datapath registers = 0
  - `o_ready` reads 1
- Latency: with the accept edge counted as edge 0, `o_valid` rises after edge 2*WIDTH+1 (edge 33 for WIDTH=16).
- Minimum issue interval: 2*WIDTH+3 cycles (DONE lasts at least one cycle, and IDLE lasts at least one cycle).
- `i_num` and `i_den` are sampled only on the accept edge. Changes on them at any other time have no effect.
- Reset mid-operation aborts immediately. No `o_valid` pulse follows, and `o_ready` reads 1 from the cycle reset asserts.
- `i_ready` high before DONE is ignored.
- `i_valid` held high through DONE is accepted at the first IDLE cycle.

## Structure
- `cdiv_pkg` holds:
  - the state enum `cdiv_state_e`
  - localparams for the product width (2*WIDTH+1) and the dividend width (2*WIDTH+1+FRAC)
  - the saturation constants 0x7FFF and 0x8000, derived from WIDTH
- Sub-module `cdiv_udiv`: an iterative unsigned restoring divider with one step per cycle. Its ports are start, dividend, divisor, busy/done, and quotient. It is instantiated once and reused for both the real and imag phases.
- The top level holds the FSM, the product registers, the overflow precheck, and sign/saturation.

## Test plan
All values are WIDTH=16, FRAC=12.

1. (1+0i)/(1+0i): `i_num` = {0x1000, 0x0000}, `i_den` = {0x1000, 0x0000} -> `o_quot` = {0x1000, 0x0000}, `o_div0` = 0, `o_valid` exactly 33 cycles after the accept edge.
2. (1+i)/(1-i): `i_num` = {0x1000, 0x1000}, `i_den` = {0x1000, 0xF000} -> `o_quot` = {0x0000, 0x1000}.
3. 2/(0.5i): `i_num` = {0x2000, 0x0000}, `i_den` = {0x0000, 0x0800} -> `o_quot` = {0x0000, 0xC000}.
4. Saturation, 7/0.25: `i_num` = {0x7000, 0x0000}, `i_den` = {0x0400, 0x0000} -> `o_quot` = {0x7FFF, 0x0000}. Also run the negated numerator {0x9000, 0x0000} -> `o_quot` = {0x8000, 0x0000}.
5. Divide by zero: `i_den` = {0x0000, 0x0000}, any numerator -> `o_quot` = 0, `o_div0` = 1, latency still 33 cycles.
6. Backpressure and reset:
   - Hold `i_ready` = 0 for 5 cycles in DONE -> `o_quot` stable and `o_valid` held, then handshake -> IDLE.
   - Next, assert `i_rst` 10 cycles after an accept -> no `o_valid`, `o_ready` = 1, and the next operation completes correctly.
